// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the iteration counter for an n-bit operand.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_multiplier_cska.sv
// Carry-skip adder built from 4-bit ripple blocks.
// A block whose bits all propagate forwards its incoming carry directly.
// Ports: A, B operands; CIN carry in; SUM; COUT unsigned carry out;
//        OVF signed overflow.
module seq_multiplier_cska #(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] A,
    input  logic [size-1:0] B,
    input  logic            CIN,
    output logic [size-1:0] SUM,
    output logic            COUT,
    output logic            OVF
);

    localparam int unsigned BLK  = 4;
    localparam int unsigned NBLK = size / BLK;

    logic        c;
    logic        cblk;
    logic        cmsb;
    logic        pall;
    logic        p;
    int unsigned idx;

    // Ripple within each block; the skip mux replaces the block carry-out when all bits propagate.
    always_comb begin
        SUM  = '0;
        c    = CIN;
        cblk = 1'b0;
        cmsb = 1'b0;
        pall = 1'b0;
        p    = 1'b0;
        idx  = 0;
        for (int unsigned bk = 0; bk < NBLK; bk++) begin
            cblk = c;
            pall = 1'b1;
            for (int unsigned i = 0; i < BLK; i++) begin
                idx      = bk * BLK + i;
                p        = A[idx] ^ B[idx];
                SUM[idx] = p ^ c;
                if (idx == size - 1) begin
                    cmsb = c;
                end
                c    = (A[idx] & B[idx]) | (p & c);
                pall = pall & p;
            end
            if (pall) begin
                c = cblk;
            end
        end
        COUT = c;
        OVF  = cmsb ^ c;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned radix-2 shift-and-add multiplier: one add/shift per cycle, size iterations.
// Ports: CLK, RST_N (async active-low); IN_VALID/IN_READY with operands A, B;
//        OUT_VALID/OUT_READY with PRODUCT (2*size bits); BUSY while iterating.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [size-1:0]   A,
    input  logic [size-1:0]   B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [2*size-1:0] PRODUCT,
    output logic              BUSY
);

    localparam int unsigned CW = cnt_width(size);

    state_t          state;
    logic [size-1:0] mcand;
    logic [size-1:0] acc;
    logic [size-1:0] q;
    logic [CW-1:0]   cnt;

    logic [size-1:0] sum;
    logic            cout;
    logic            cska_ovf_unused;
    logic [size-1:0] nxt;
    logic            c;

    seq_multiplier_cska #(.size(size)) u_cska (
        .A    (acc),
        .B    (mcand),
        .CIN  (1'b0),
        .SUM  (sum),
        .COUT (cout),
        .OVF  (cska_ovf_unused)
    );

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        nxt = q[0] ? sum : acc;
        c   = q[0] & cout;
    end

    assign PRODUCT = {acc, q};

    // FSM, datapath and registered handshake flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            acc       <= '0;
            q         <= '0;
            cnt       <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        mcand    <= A;
                        q        <= B;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ST_RUN;
                        IN_READY <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Logical right shift of {carry, partial sum, multiplier}.
                    acc <= {c, nxt[size-1:1]};
                    q   <= {nxt[0], q[size-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(size - 1)) begin
                        state     <= ST_DONE;
                        BUSY      <= 1'b0;
                        OUT_VALID <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        state     <= ST_IDLE;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    IN_READY  <= 1'b1;
                    OUT_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed 32-bit vectors plus a size-8 random sweep.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    logic        in_valid_8;
    logic        in_ready_8;
    logic [7:0]  a_8;
    logic [7:0]  b_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [15:0] product_8;
    logic        busy_8;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.size(32)) dut32 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .PRODUCT   (product),
        .BUSY      (busy)
    );

    seq_multiplier #(.size(8)) dut8 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid_8),
        .IN_READY  (in_ready_8),
        .A         (a_8),
        .B         (b_8),
        .OUT_VALID (out_valid_8),
        .OUT_READY (out_ready_8),
        .PRODUCT   (product_8),
        .BUSY      (busy_8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 32-bit multiply with OUT_READY held high.
    task automatic op32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " in_ready low"}, 64'(in_ready), 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd32);
        check({tag, " product"}, product, exp);
        @(posedge clk); #1;
        check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0]  av8;
        logic [7:0]  bv8;
        logic [15:0] exp8;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;
        in_valid_8  = 1'b0;
        a_8         = '0;
        b_8         = '0;
        out_ready_8 = 1'b0;

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op32("3x5", 32'd3, 32'd5, 64'd15);
        op32("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        op32("0xdead", 32'd0, 32'hDEAD_BEEF, 64'd0);
        op32("msbx2", 32'h8000_0000, 32'd2, 64'h1_0000_0000);

        // Backpressure with operand pulses during RUN and DONE.
        out_ready = 1'b0;
        a         = 32'd12;
        b         = 32'd11;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        a = 32'd99;
        b = 32'd77;
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc = 6;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp latency", 64'(cyc), 64'd32);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~i[0];
            check("bp product stable", product, 64'd132);
            check("bp out_valid held", 64'(out_valid), 64'd1);
            check("bp in_ready low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp out_valid drop", 64'(out_valid), 64'd0);
        check("bp in_ready back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("bp nothing queued", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of an iteration.
        a        = 32'd1234;
        b        = 32'd5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst out_valid", 64'(out_valid), 64'd0);
        op32("7x9", 32'd7, 32'd9, 64'd63);

        // size=8 instance: random operands and random output backpressure.
        for (int i = 0; i < 1000; i++) begin
            av8  = 8'($urandom_range(0, 255));
            bv8  = 8'($urandom_range(0, 255));
            exp8 = 16'(av8) * 16'(bv8);
            cyc  = 0;
            while (!in_ready_8 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            a_8         = av8;
            b_8         = bv8;
            in_valid_8  = 1'b1;
            out_ready_8 = 1'b0;
            @(posedge clk); #1;
            in_valid_8 = 1'b0;
            cyc = 0;
            while (!out_valid_8 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("r8 latency", 64'(cyc), 64'd8);
            check("r8 product", 64'(product_8), 64'(exp8));
            cyc = 0;
            do begin
                out_ready_8 = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                cyc++;
                if (out_valid_8) begin
                    check("r8 hold", 64'(product_8), 64'(exp8));
                end
            end while (out_valid_8 && cyc < 100);
            out_ready_8 = 1'b0;
            check("r8 handshake", 64'(out_valid_8), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Unsigned radix-2 shift-and-add multiplier that sits directly downstream of the carry-skip adder. It is the adder's consumer, using the adder's SUM and COUT every iteration. It accepts two `size`-bit operands over a valid/ready handshake, runs `size` add/shift iterations through one instance of the team's carry-skip adder (CSKA), and presents a `2*size`-bit product held until the consumer takes it. It is the multi-cycle multiply path in the ALU explorer, next to the single-cycle adders.

## Interface
- `size`, default 32: operand width. Must be a multiple of 4 (CSKA block granularity) and at least 4.
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `IN_VALID`, input, 1: operands A/B valid.
- `IN_READY`, output, 1: block can accept operands.
- `A`, input, `size`: multiplicand, unsigned.
- `B`, input, `size`: multiplier, unsigned.
- `OUT_VALID`, output, 1: PRODUCT valid.
- `OUT_READY`, input, 1: consumer takes PRODUCT.
- `PRODUCT`, output, `2*size`: A*B, unsigned, exact.
- `BUSY`, output, 1: iteration in progress (state RUN).

## Operation
- Registers:
  - MCAND (`size` bits).
  - ACC (`size` bits): upper product half.
  - Q (`size` bits): multiplier, shifting into the lower product half.
  - CNT (`$clog2(size)` bits).
  - STATE.
- FSM states:
  - IDLE: `IN_READY`=1. On `IN_VALID`&`IN_READY`: MCAND<=A, Q<=B, ACC<=0, CNT<=0, go to RUN.
  - RUN: one iteration per cycle.
    - The adder computes ACC+MCAND with CIN=0, giving {COUT,SUM}.
    - If Q[0]=1, then {C,NEXT}={COUT,SUM}. Otherwise {C,NEXT}={0,ACC}.
    - {ACC,Q} <= {C,NEXT,Q[size-1:1]}, a logical right shift of the `2*size+1`-bit concatenation.
    - CNT<=CNT+1. When CNT==size-1, go to DONE.
  - DONE: `OUT_VALID`=1, `PRODUCT`={ACC,Q}. On `OUT_READY`=1, go to IDLE.
- Arithmetic rules:
  - The adder's OVF output is left unconnected. The unsigned carry is taken only from COUT.
  - The product never exceeds `2*size` bits. The carry C always lands in ACC[size-1] and is never lost.
- Handshake rules:
  - `IN_VALID` is ignored outside IDLE. A, B and `IN_VALID` have no effect in RUN or DONE, and there is no queuing.
  - `PRODUCT` and `OUT_VALID` stay stable while `OUT_VALID`=1 and `OUT_READY`=0, with unlimited backpressure.
  - There is no overlap: a new operand pair is accepted only after the DONE→IDLE transition, so at the earliest one cycle after the output handshake.
- `PRODUCT` outside DONE: drive `PRODUCT` = {ACC,Q} unconditionally. Consumers qualify it with `OUT_VALID` only.
- Reset (`RST_N`=0, at any time including mid-RUN or in DONE):
  - STATE=IDLE; MCAND, ACC, Q and CNT all 0.
  - Outputs: `IN_READY`=1, `OUT_VALID`=0, `BUSY`=0, `PRODUCT`=0.
  - Any in-flight operation is discarded. No output is produced for it.
- Degenerate operands: A=0 or B=0 still take the full `size` iterations. There is no early termination.

## Timing
- Accept at rising edge k, meaning `IN_VALID`&`IN_READY` are sampled high.
- `BUSY`=1 during cycles k..k+size-1.
- `OUT_VALID` rises after edge k+size. Latency from accept to `OUT_VALID` is `size` cycles; with `size`=32 it is 32.
- `IN_READY` falls after edge k and rises again after the edge on which `OUT_VALID`&`OUT_READY` is sampled high.
- Throughput is one product per `size`+2 cycles when `OUT_READY` is held at 1.
- The critical path is the CSKA ripple/skip chain plus the 2:1 mux into ACC. No other arithmetic sits on that path.

## Structure
- Shared package `mult_pkg`:
  - State encoding constants: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - Helper for the CNT width, `$clog2(size)`.
- One sub-module: a single CSKA instance, `#(size)`, with A=ACC, B=MCAND, CIN=0. SUM and COUT are used; OVF is unused.
- Everything else is flat in `seq_multiplier`: the FSM, counter, shift register and the output mux.

## Test plan
- `size`=32, A=3, B=5, `OUT_READY`=1 → `OUT_VALID` exactly 32 cycles after accept, `PRODUCT`=64'd15, `IN_READY` back 1 cycle later.
- A=B=32'hFFFFFFFF → `PRODUCT`=64'hFFFFFFFE00000001. This exercises COUT on every iteration.
- A=0, B=32'hDEADBEEF → `PRODUCT`=0, still 32-cycle latency. A=32'h80000000, B=2 → `PRODUCT`=64'h100000000.
- `OUT_READY`=0 for 10 cycles in DONE with new `IN_VALID` pulses during RUN and DONE → `PRODUCT` stable, no operand accepted, `IN_READY`=0 until the output handshake.
- `RST_N` pulsed low at RUN cycle 17 → all outputs at reset values immediately (asynchronous). The next operation, A=7, B=9, yields 63 with full latency.
- `size`=8 instance, random 1000 operand pairs with random `OUT_READY` → `PRODUCT` equals the reference A*B every time, and latency is always 8.
